// File: rtl/hll_bucket_update.sv
// hll_bucket_update: HyperLogLog register-update stage.
// Each accepted 64-bit hash is split into a P-bit bucket index and a rank.
// The bucket register is max-updated through a two-stage read/compare/write pipeline.
// A dump sequence streams every bucket register to the downstream estimator.
// Optional feature macro: HLL_CLEAR_ON_DUMP_EN. When defined, a dump clears each
// register after reading it, and clears upd_count together with rd_last.
module hll_bucket_update #(
  parameter int P     = 14,
  parameter int REG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      hash,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rd_start,
  output logic             rd_valid,
  output logic [P-1:0]     rd_idx,
  output logic [REG_W-1:0] rd_data,
  output logic             rd_last,
  output logic [31:0]      upd_count,
  output logic             busy
);

  localparam int DEPTH = 1 << P;
  localparam int W_W   = 64 - P;

  typedef enum logic [1:0] {INIT, RUN, DRAIN, DUMP} state_t;

  state_t           state, state_nxt;
  logic [P-1:0]     addr_cnt;
  logic             dump_tail;
  logic             drain_cnt;
  logic             accept;
  logic             dump_issue;

  logic [P-1:0]     idx_in;
  logic [W_W-1:0]   w_in;
  logic [REG_W-1:0] rho_in;

  logic             s1_valid;
  logic [P-1:0]     s1_idx;
  logic [REG_W-1:0] s1_rho;

  logic             s2_valid;
  logic [P-1:0]     s2_idx;
  logic [REG_W-1:0] s2_rho;
  logic             s2_fwd;
  logic [REG_W-1:0] s2_fwd_val;
  logic [REG_W-1:0] old_val;
  logic             s2_wr_upd;

  logic [REG_W-1:0] mem [DEPTH];
  logic [REG_W-1:0] ram_q;
  logic [P-1:0]     ram_raddr;
  logic             ram_we;
  logic [P-1:0]     ram_waddr;
  logic [REG_W-1:0] ram_wdata;

  assign in_ready   = (state == RUN);
  assign busy       = (state != RUN);
  assign accept     = in_valid && in_ready;
  assign dump_issue = (state == DUMP) && !dump_tail;
  assign idx_in     = hash[63:64-P];
  assign w_in       = hash[63-P:0];

  // Rank = leading zeros of the remainder plus one; an all-zero remainder gets the maximum rank.
  always_comb begin
    rho_in = REG_W'(65 - P);
    for (int i = 0; i < W_W; i++) begin
      if (w_in[i]) rho_in = REG_W'(64 - P - i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next-state logic: clear the RAM, run, let the pipeline empty, then dump.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (addr_cnt == '1) state_nxt = RUN;
      RUN:     if (rd_start) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DUMP;
      DUMP:    if (dump_tail) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Address counter shared by INIT clearing and DUMP reads, plus the drain/tail markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt  <= '0;
      dump_tail <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      dump_tail <= dump_issue && (addr_cnt == '1);
      if (state == INIT || dump_issue) addr_cnt <= addr_cnt + P'(1);
    end
  end

  // Stage 1 captures the accepted bucket index and rank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_rho   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx <= idx_in;
        s1_rho <= rho_in;
      end
    end
  end

  assign ram_raddr = dump_issue ? addr_cnt : s1_idx;
  assign old_val   = s2_fwd ? s2_fwd_val : ram_q;
  assign s2_wr_upd = s2_valid && (s2_rho > old_val);

  // Stage 2 holds the update while the RAM returns the old value; a same-index
  // write happening while stage 1 reads is forwarded because the RAM returns stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_idx     <= '0;
      s2_rho     <= '0;
      s2_fwd     <= 1'b0;
      s2_fwd_val <= '0;
    end else begin
      s2_valid   <= s1_valid;
      s2_idx     <= s1_idx;
      s2_rho     <= s1_rho;
      s2_fwd     <= s2_wr_upd && s1_valid && (s2_idx == s1_idx);
      s2_fwd_val <= s2_rho;
    end
  end

  // Single write port arbitration: INIT clearing, dump clearing, then pipeline updates.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_idx;
    ram_wdata = s2_rho;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = addr_cnt;
      ram_wdata = '0;
    end
`ifdef HLL_CLEAR_ON_DUMP_EN
    else if (rd_valid) begin
      ram_we    = 1'b1;
      ram_waddr = rd_idx;
      ram_wdata = '0;
    end
`endif
    else if (s2_wr_upd) begin
      ram_we = 1'b1;
    end
  end

  // Register file: one write port, one synchronous read port returning old data on collision.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // Dump output qualifiers trail the issued read address by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= dump_issue;
      rd_last  <= dump_issue && (addr_cnt == '1);
      if (dump_issue) rd_idx <= addr_cnt;
    end
  end

  assign rd_data = rd_valid ? ram_q : '0;

  // Count committed register updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_count <= '0;
    end
`ifdef HLL_CLEAR_ON_DUMP_EN
    else if (rd_valid && rd_last) begin
      upd_count <= '0;
    end
`endif
    else if (s2_wr_upd) begin
      upd_count <= upd_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hll_bucket_update.sv
// Testbench for hll_bucket_update with P=4, REG_W=6.
// Expectations follow HLL_CLEAR_ON_DUMP_EN when it is defined for the build.
module tb_hll_bucket_update;

  localparam int P     = 4;
  localparam int REG_W = 6;
  localparam int DEPTH = 16;
`ifdef HLL_CLEAR_ON_DUMP_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [63:0]      hash = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             rd_start = 1'b0;
  logic             rd_valid;
  logic [P-1:0]     rd_idx;
  logic [REG_W-1:0] rd_data;
  logic             rd_last;
  logic [31:0]      upd_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [REG_W-1:0] dump_data [32];
  logic [P-1:0]     dump_idx  [32];
  logic             dump_last [32];
  int               dump_n;
  int               first_k;
  int               ready_k;
  logic [REG_W-1:0] exp_reg   [DEPTH];

  hll_bucket_update #(.P(P), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .hash(hash), .in_valid(in_valid), .in_ready(in_ready),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_last(rd_last), .upd_count(upd_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int k;
    rst = 1'b1; in_valid = 1'b0; rd_start = 1'b0; hash = '0;
    tick(); tick();
    rst = 1'b0;
    k = 0;
    while (!in_ready && k < 40) begin tick(); k++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_done in_ready %b want 1", in_ready);
    end
  endtask

  task automatic send(input logic [63:0] h);
    hash = h; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic settle();
    tick(); tick(); tick();
  endtask

  task automatic clear_exp();
    for (int i = 0; i < DEPTH; i++) exp_reg[i] = '0;
  endtask

  // Issue rd_start (optionally with a coincident hash) and capture the dump words.
  task automatic run_dump(input logic with_hash, input logic [63:0] h);
    rd_start = 1'b1;
    if (with_hash) begin hash = h; in_valid = 1'b1; end
    tick();
    rd_start = 1'b0; in_valid = 1'b0;
    dump_n = 0; first_k = 0; ready_k = 0;
    for (int k = 1; k <= 60; k++) begin
      if (rd_valid) begin
        if (dump_n == 0) first_k = k;
        if (dump_n < 32) begin
          dump_data[dump_n] = rd_data;
          dump_idx[dump_n]  = rd_idx;
          dump_last[dump_n] = rd_last;
        end
        dump_n++;
      end
      if (in_ready) begin ready_k = k; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    int low;
    rst = 1'b1;
    tick();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_idx !== 4'd0) begin errors++; $display("[TB] FAIL rst_rd_idx got %0d want 0", rd_idx); end
    checks++; if (rd_data !== 6'd0) begin errors++; $display("[TB] FAIL rst_rd_data got %0d want 0", rd_data); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_last got %b want 0", rd_last); end
    checks++; if (upd_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_upd_count got %0d want 0", upd_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy got %b want 1", busy); end
    tick();
    rst = 1'b0;
    low = 0;
    while (!in_ready && low < 40) begin low++; tick(); end
    checks++;
    if (low !== 16) begin errors++; $display("[TB] FAIL init_low_cycles got %0d want 16", low); end
    clear_exp();
    run_dump(1'b0, 64'd0);
    checks++; if (first_k !== 4) begin errors++; $display("[TB] FAIL reset_dump_first got %0d want 4", first_k); end
    checks++; if (ready_k !== 20) begin errors++; $display("[TB] FAIL reset_dump_ready got %0d want 20", ready_k); end
    checks++; if (dump_n !== 16) begin errors++; $display("[TB] FAIL reset_dump_words got %0d want 16", dump_n); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dump_idx[i] !== 4'(i) || dump_data[i] !== exp_reg[i] || dump_last[i] !== (i == 15)) begin
        errors++;
        $display("[TB] FAIL reset_dump[%0d] got idx %0d data %0d last %b want idx %0d data %0d last %b",
                 i, dump_idx[i], dump_data[i], dump_last[i], i, exp_reg[i], (i == 15));
      end
    end
  endtask

  task automatic test_rank();
    do_reset();
    send(64'h0000_0000_0000_0001);
    send(64'hF800_0000_0000_0000);
    send(64'hF000_0000_0000_0000);
    settle();
    checks++; if (upd_count !== 32'd3) begin errors++; $display("[TB] FAIL rank_upd_count got %0d want 3", upd_count); end
    clear_exp();
    exp_reg[0] = 6'd60; exp_reg[15] = 6'd61;
    run_dump(1'b0, 64'd0);
    checks++; if (dump_n !== 16) begin errors++; $display("[TB] FAIL rank_dump_words got %0d want 16", dump_n); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dump_data[i] !== exp_reg[i]) begin
        errors++;
        $display("[TB] FAIL rank_reg[%0d] got %0d want %0d", i, dump_data[i], exp_reg[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    send(64'h3080_0000_0000_0000);
    send(64'h3400_0000_0000_0000);
    settle();
    checks++; if (upd_count !== 32'd1) begin errors++; $display("[TB] FAIL fwd_a_upd_count got %0d want 1", upd_count); end
    run_dump(1'b0, 64'd0);
    checks++; if (dump_data[3] !== 6'd5) begin errors++; $display("[TB] FAIL fwd_a_reg3 got %0d want 5", dump_data[3]); end
    do_reset();
    send(64'h3400_0000_0000_0000);
    send(64'h3080_0000_0000_0000);
    settle();
    checks++; if (upd_count !== 32'd2) begin errors++; $display("[TB] FAIL fwd_b_upd_count got %0d want 2", upd_count); end
    run_dump(1'b0, 64'd0);
    checks++; if (dump_data[3] !== 6'd5) begin errors++; $display("[TB] FAIL fwd_b_reg3 got %0d want 5", dump_data[3]); end
  endtask

  task automatic test_coincident();
    do_reset();
    run_dump(1'b1, 64'h7400_0000_0000_0000);
    clear_exp();
    exp_reg[7] = 6'd2;
    checks++; if (ready_k !== 20) begin errors++; $display("[TB] FAIL coin_ready got %0d want 20", ready_k); end
    checks++; if (first_k !== 4) begin errors++; $display("[TB] FAIL coin_first got %0d want 4", first_k); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dump_data[i] !== exp_reg[i]) begin
        errors++;
        $display("[TB] FAIL coin_reg[%0d] got %0d want %0d", i, dump_data[i], exp_reg[i]);
      end
    end
    checks++;
    if (upd_count !== (CLEAR ? 32'd0 : 32'd1)) begin
      errors++;
      $display("[TB] FAIL coin_upd_count got %0d want %0d", upd_count, (CLEAR ? 0 : 1));
    end
  endtask

  task automatic test_reset_mid_dump();
    int k;
    int low;
    do_reset();
    send(64'h0000_0000_0000_0001);
    settle();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    k = 0;
    while (!(rd_valid && rd_idx == 4'd8) && k < 40) begin tick(); k++; end
    checks++;
    if (!(rd_valid === 1'b1 && rd_idx === 4'd8)) begin
      errors++;
      $display("[TB] FAIL mid_dump_reach got valid %b idx %0d want valid 1 idx 8", rd_valid, rd_idx);
    end
    rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rd_valid got %b want 0", rd_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_busy got %b want 1", busy); end
    tick();
    rst = 1'b0;
    low = 0;
    while (!in_ready && low < 40) begin low++; tick(); end
    checks++; if (low !== 16) begin errors++; $display("[TB] FAIL mid_init_low got %0d want 16", low); end
    run_dump(1'b0, 64'd0);
    checks++; if (dump_n !== 16) begin errors++; $display("[TB] FAIL mid_dump_words got %0d want 16", dump_n); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dump_data[i] !== 6'd0) begin
        errors++;
        $display("[TB] FAIL mid_reg[%0d] got %0d want 0", i, dump_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back_dumps();
    do_reset();
    send(64'h0000_0000_0000_0001);
    send(64'h7400_0000_0000_0000);
    send(64'hF000_0000_0000_0000);
    settle();
    clear_exp();
    exp_reg[0] = 6'd60; exp_reg[7] = 6'd2; exp_reg[15] = 6'd61;
    run_dump(1'b0, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dump_data[i] !== exp_reg[i]) begin
        errors++;
        $display("[TB] FAIL b2b_first[%0d] got %0d want %0d", i, dump_data[i], exp_reg[i]);
      end
    end
    checks++;
    if (upd_count !== (CLEAR ? 32'd0 : 32'd3)) begin
      errors++;
      $display("[TB] FAIL b2b_upd_count got %0d want %0d", upd_count, (CLEAR ? 0 : 3));
    end
    if (CLEAR) clear_exp();
    tick();
    run_dump(1'b0, 64'd0);
    checks++; if (dump_n !== 16) begin errors++; $display("[TB] FAIL b2b_second_words got %0d want 16", dump_n); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dump_data[i] !== exp_reg[i]) begin
        errors++;
        $display("[TB] FAIL b2b_second[%0d] got %0d want %0d", i, dump_data[i], exp_reg[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rank();
    test_forwarding();
    test_coincident();
    test_reset_mid_dump();
    test_back_to_back_dumps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/hll_bucket_update.md
# hll_bucket_update

HyperLogLog register-update stage that sits directly downstream of the 64-bit MurmurHash3 finalizer pipeline. It consumes one 64-bit hash per cycle, splits it into a P-bit bucket index and a rank value, and max-updates a 2^P-entry register file. A dump sequence streams the register file to the downstream cardinality estimator.

## Interface
Parameters:
- P, 14, precision; bucket index width; legal range 4..16
- REG_W, 6, register width; must hold 65-P

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- hash  in  64  hash word from the finalizer
- in_valid  in  1  hash qualifier
- in_ready  out  1  block accepts hash this cycle
- rd_start  in  1  single-cycle request to dump the register file
- rd_valid  out  1  dump word valid
- rd_idx  out  P  bucket index of the dump word
- rd_data  out  REG_W  register value of the dump word
- rd_last  out  1  marks index 2^P-1
- upd_count  out  32  number of register writes since reset; wraps
- busy  out  1  high in INIT, DRAIN and DUMP

## Operation
- Accept when in_valid && in_ready. in_valid while in_ready=0 is ignored; the hash is dropped.
- Index: idx = hash[63:64-P]. Remainder: w = hash[63-P:0].
- Rank: rho = (leading zeros of w) + 1. If w=0, rho = 65-P.
- Update: if rho > reg[idx], write reg[idx] = rho and increment upd_count. Otherwise, no write.
- Register RAM: single write port and one synchronous read port with 1-cycle latency. Read-during-write to the same address returns old data.
- Pipeline stages:
  - S1 registers idx, rho and valid.
  - S1 issues the RAM read.
  - S2 compares and writes.
- Forwarding: if S2 writes idx X in the same cycle S1 reads idx X, S2 uses the written value as "old" on the next cycle. Back-to-back same-index hashes must behave as strictly sequential updates.
- States:
  - INIT (reset state): writes 0 to addresses 0..2^P-1, one per cycle; in_ready=0. Goes to RUN after address 2^P-1.
  - RUN: in_ready=1. On rd_start, goes to DRAIN. A hash with in_valid in the same cycle is still accepted.
  - DRAIN: in_ready=0 for 2 cycles until S1 and S2 are empty, then goes to DUMP.
  - DUMP: issues read addresses 0..2^P-1, one per cycle. Each rd_valid/rd_idx/rd_data appears 1 cycle after its address is issued. rd_last is asserted with idx 2^P-1. Returns to RUN the cycle after rd_last.
- rd_start outside RUN is ignored.
- Reset asserted at any time, including mid-dump or mid-update, aborts the operation and restarts INIT. Partial dumps are not resumed.

## Timing
- Reset values: in_ready=0, rd_valid=0, rd_idx=0, rd_data=0, rd_last=0, upd_count=0, busy=1.
- After rst deasserts, in_ready rises 2^P cycles later.
- Hash accepted at cycle t: the write commits at the edge ending cycle t+2. A dump started afterwards reflects it.
- rd_start at cycle t:
  - DRAIN covers t+1 and t+2.
  - First rd_valid at t+4.
  - rd_last at t+3+2^P.
  - in_ready=1 again at t+4+2^P.
- Throughput: 1 hash per cycle in RUN, with no bubbles for same-index bursts.
- rd_valid has no backpressure; the consumer must take every word.

## Configuration
- HLL_CLEAR_ON_DUMP_EN
  - Defined: DUMP writes 0 to each address in the cycle after its read is issued. The register file is empty when the block returns to RUN, and upd_count is cleared with rd_last.
  - Undefined: DUMP is read-only; registers and upd_count persist across dumps.

## Test plan
(P=4, REG_W=6)
- Reset release → in_ready=0 for 16 cycles, then 1. An immediate dump returns 16 words, all rd_data=0, rd_last on idx 15.
- Rank values:
  - 0x0000_0000_0000_0001 → reg[0]=60.
  - 0xF800_0000_0000_0000 → reg[15]=1.
  - 0xF000_0000_0000_0000 → reg[15]=61.
  - upd_count=3.
- Forwarding: back-to-back 0x3080_0000_0000_0000 (rho 5) then 0x3400_0000_0000_0000 (rho 2) → reg[3]=5, upd_count=1. Reversed order → reg[3]=5, upd_count=2.
- rd_start coincident with in_valid on 0x7400_0000_0000_0000 → hash accepted; dump shows reg[7]=2; in_ready low for exactly 2+1+16 cycles.
- rst asserted mid-dump at idx 8 → rd_valid=0 immediately; INIT reruns; the next dump is all zeros.
- Two dumps with no intervening input:
  - HLL_CLEAR_ON_DUMP_EN defined → the second dump is all zeros.
  - HLL_CLEAR_ON_DUMP_EN undefined → the second dump is identical to the first.
